// File: rtl/pwm_fade_ctrl_pkg.sv
// Shared types and constants for the PWM fade controller.
// Also used by the optional PWM_FADE_BREATHE_EN build.
package pwm_ctrl_pkg;

  localparam int DUTY_W_DEF  = 8;
  localparam int PRESC_W_DEF = 16;

  // A requested step of zero would never reach the target.
  localparam logic [3:0] STEP_MIN = 4'd1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } fade_state_e;

  function automatic logic [3:0] norm_step(input logic [3:0] s);
    return (s == 4'd0) ? STEP_MIN : s;
  endfunction

endpackage

// File: rtl/pwm_fade_ctrl_if.sv
// Fade command channel between the SPI requester and the fade controller.
// Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready; the requester holds it until then.
interface pwm_fade_if
  import pwm_ctrl_pkg::*;
#(
    parameter int DUTY_W  = DUTY_W_DEF,
    parameter int PRESC_W = PRESC_W_DEF
);

  logic               cmd_valid;
  logic               cmd_ready;
  logic [DUTY_W-1:0]  cmd_target;
  logic [3:0]         cmd_step;
  logic [PRESC_W-1:0] cmd_prescale;
  logic               cmd_breathe;
  logic [DUTY_W-1:0]  cmd_floor;
  logic               abort;

  modport master(
      output cmd_valid, cmd_target, cmd_step, cmd_prescale, cmd_breathe, cmd_floor, abort,
      input  cmd_ready
  );

  modport slave(
      input  cmd_valid, cmd_target, cmd_step, cmd_prescale, cmd_breathe, cmd_floor, abort,
      output cmd_ready
  );

endinterface

// File: rtl/pwm_fade_ctrl_step_timer.sv
// Step-interval counter: step_tick is high in the cycle whose edge applies one step,
// i.e. every prescale+1 enabled cycles after a clear.
module pwm_step_timer #(
    parameter int PRESC_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               enable,
    input  logic [PRESC_W-1:0] prescale,
    output logic               step_tick
);

  logic [PRESC_W-1:0] cnt;

  assign step_tick = enable && (cnt == prescale);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == prescale) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pwm_fade_ctrl.sv
// Duty-cycle ramp controller: walks duty_out toward a commanded target in saturating steps.
// Define PWM_FADE_BREATHE_EN to enable breathing between cmd_floor and cmd_target.
module pwm_fade_ctrl
  import pwm_ctrl_pkg::*;
#(
    parameter int DUTY_W  = DUTY_W_DEF,
    parameter int PRESC_W = PRESC_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    pwm_fade_if.slave         cmd,
    output logic [DUTY_W-1:0] duty_out,
    output logic              busy,
    output logic              done,
    output logic [1:0]        dbg_state
);

  localparam logic [1:0] IDLE = 2'(ST_IDLE);
  localparam logic [1:0] UP   = 2'(ST_UP);
  localparam logic [1:0] DOWN = 2'(ST_DOWN);

  logic [1:0]         state;
  logic [DUTY_W-1:0]  goal_q;
  logic [3:0]         step_q;
  logic [PRESC_W-1:0] presc_q;
  logic               accept;
  logic               step_tick;
  logic [DUTY_W:0]    step_ext;
  logic [DUTY_W:0]    sum;
  logic [DUTY_W:0]    diff;
  logic [DUTY_W-1:0]  up_val;
  logic [DUTY_W-1:0]  down_val;
  logic [DUTY_W-1:0]  next_duty;

`ifdef PWM_FADE_BREATHE_EN
  logic               breathe_q;
  logic [DUTY_W-1:0]  target_q;
  logic [DUTY_W-1:0]  floor_q;
`else
  logic               breathe_unused;
  assign breathe_unused = &{1'b0, cmd.cmd_breathe, cmd.cmd_floor};
`endif

  assign dbg_state     = state;
  assign cmd.cmd_ready = (state == IDLE) && !cmd.abort;
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;

  // One bit of headroom so the sum cannot wrap and the difference exposes a borrow.
  assign step_ext = {{(DUTY_W - 3){1'b0}}, step_q};
  assign sum      = {1'b0, duty_out} + step_ext;
  assign diff     = {1'b0, duty_out} - step_ext;
  assign up_val   = (sum > {1'b0, goal_q}) ? goal_q : sum[DUTY_W-1:0];
  assign down_val = (diff[DUTY_W] || (diff[DUTY_W-1:0] < goal_q)) ? goal_q : diff[DUTY_W-1:0];
  assign next_duty = (state == UP) ? up_val : down_val;

  pwm_step_timer #(
      .PRESC_W(PRESC_W)
  ) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (accept),
      .enable   (state != IDLE),
      .prescale (presc_q),
      .step_tick(step_tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      duty_out <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      goal_q   <= '0;
      step_q   <= '0;
      presc_q  <= '0;
`ifdef PWM_FADE_BREATHE_EN
      breathe_q <= 1'b0;
      target_q  <= '0;
      floor_q   <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            goal_q  <= cmd.cmd_target;
            step_q  <= norm_step(cmd.cmd_step);
            presc_q <= cmd.cmd_prescale;
`ifdef PWM_FADE_BREATHE_EN
            breathe_q <= cmd.cmd_breathe && (cmd.cmd_floor < cmd.cmd_target);
            target_q  <= cmd.cmd_target;
            floor_q   <= cmd.cmd_floor;
`endif
            if (cmd.cmd_target > duty_out) begin
              state <= UP;
              busy  <= 1'b1;
            end else if (cmd.cmd_target < duty_out) begin
              state <= DOWN;
              busy  <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end
        end
        UP, DOWN: begin
          if (cmd.abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (step_tick) begin
            duty_out <= next_duty;
            if (next_duty == goal_q) begin
`ifdef PWM_FADE_BREATHE_EN
              // Reaching the target heads for the floor; anything else heads back up.
              if (breathe_q) begin
                if (goal_q == target_q) begin
                  state  <= DOWN;
                  goal_q <= floor_q;
                end else begin
                  state  <= UP;
                  goal_q <= target_q;
                end
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
`else
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
`endif
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
